// File: rtl/ran_conditioner.sv
// rtl/ran_conditioner.sv - raw entropy health tests (RCT/APT) and von Neumann debiaser
// Optional discard statistics output enabled by macro COND_STATS_EN.
module ran_conditioner #(
  parameter int RCT_CUTOFF = 32,
  parameter int APT_WINDOW = 512,
  parameter int APT_CUTOFF = 410
) (
  input  logic       i_sysClock,
  input  logic       wb_rst_i,
  input  logic       i_enb,
  input  logic       i_sample,
  input  logic       i_ranBit,
  input  logic       i_clearFail,
  output logic       o_bit,
  output logic       o_bitValid,
  output logic       o_ready,
  output logic       o_healthFail,
  output logic [1:0] o_failCause
`ifdef COND_STATS_EN
  ,
  output logic [15:0] o_discardCount
`endif
);

  localparam int RW = $clog2(RCT_CUTOFF + 1);
  localparam int IW = $clog2(APT_WINDOW);
  localparam int MW = $clog2(APT_WINDOW + 1);
  localparam logic [RW-1:0] RCT_MAX  = RW'(RCT_CUTOFF);
  localparam logic [MW-1:0] APT_MAX  = MW'(APT_CUTOFF);
  localparam logic [IW-1:0] IDX_LAST = IW'(APT_WINDOW - 1);

  typedef enum logic {S_EMPTY, S_HALF} pair_t;

  pair_t           r_state, w_next;
  logic            r_a, r_bit, r_bitValid, r_ready, r_healthFail;
  logic [1:0]      r_failCause;
  logic            r_prevValid, r_prev, r_aptRef;
  logic [RW-1:0]   r_rctCount, w_rctNext;
  logic [IW-1:0]   r_aptIdx;
  logic [MW-1:0]   r_aptMatch, w_aptNext;
  logic            w_accept, w_pairDone, w_emit, w_discard;
  logic            w_rctTrip, w_aptTrip, w_wrap;

  assign w_accept = i_enb & i_sample & ~i_clearFail;

  // Run length; the first sample after reset/clear has no predecessor.
  always_comb begin
    w_rctNext = RW'(1);
    if (r_prevValid && (i_ranBit == r_prev))
      w_rctNext = (r_rctCount == RCT_MAX) ? RCT_MAX : r_rctCount + RW'(1);
  end

  always_comb begin
    w_aptNext = r_aptMatch;
    if (r_aptIdx == '0)
      w_aptNext = MW'(1);
    else if (i_ranBit == r_aptRef)
      w_aptNext = r_aptMatch + MW'(1);
  end

  assign w_rctTrip = w_accept && (w_rctNext == RCT_MAX);
  assign w_aptTrip = w_accept && (w_aptNext == APT_MAX);
  assign w_wrap    = w_accept && (r_aptIdx == IDX_LAST);

  always_ff @(posedge i_sysClock) begin
    if (wb_rst_i)
      r_state <= S_EMPTY;
    else
      r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    if (i_clearFail || !i_enb || r_healthFail)
      w_next = S_EMPTY;
    else if (w_accept)
      w_next = (r_state == S_EMPTY) ? S_HALF : S_EMPTY;
  end

  always_comb begin
    w_pairDone = w_accept && (r_state == S_HALF) && !r_healthFail;
    w_emit     = w_pairDone && r_ready && (r_a != i_ranBit);
    w_discard  = w_pairDone && r_ready && (r_a == i_ranBit);
  end

  always_ff @(posedge i_sysClock) begin
    if (wb_rst_i) begin
      r_a          <= 1'b0;
      r_bit        <= 1'b0;
      r_bitValid   <= 1'b0;
      r_ready      <= 1'b0;
      r_healthFail <= 1'b0;
      r_failCause  <= 2'b00;
      r_prevValid  <= 1'b0;
      r_prev       <= 1'b0;
      r_rctCount   <= RW'(1);
      r_aptIdx     <= '0;
      r_aptRef     <= 1'b0;
      r_aptMatch   <= '0;
    end else if (i_clearFail) begin
      r_bitValid   <= 1'b0;
      r_ready      <= 1'b0;
      r_healthFail <= 1'b0;
      r_failCause  <= 2'b00;
      r_prevValid  <= 1'b0;
      r_rctCount   <= RW'(1);
      r_aptIdx     <= '0;
      r_aptMatch   <= '0;
    end else begin
      r_bitValid <= w_emit;
      if (w_emit)
        r_bit <= r_a;
      if (w_accept && (r_state == S_EMPTY))
        r_a <= i_ranBit;
      if (w_accept) begin
        r_prev      <= i_ranBit;
        r_prevValid <= 1'b1;
        r_rctCount  <= w_rctNext;
        if (r_aptIdx == '0)
          r_aptRef <= i_ranBit;
        r_aptMatch  <= w_aptNext;
        r_aptIdx    <= w_wrap ? '0 : r_aptIdx + IW'(1);
        if (w_rctTrip || w_aptTrip)
          r_healthFail <= 1'b1;
        r_failCause <= r_failCause | {w_aptTrip, w_rctTrip};
        // Ready only after a whole window with no failure, including its last sample.
        if (w_wrap && !r_healthFail && !w_rctTrip && !w_aptTrip)
          r_ready <= 1'b1;
      end
    end
  end

`ifdef COND_STATS_EN
  logic [15:0] r_discardCount;

  always_ff @(posedge i_sysClock) begin
    if (wb_rst_i || i_clearFail)
      r_discardCount <= 16'h0000;
    else if (w_discard && (r_discardCount != 16'hFFFF))
      r_discardCount <= r_discardCount + 16'h0001;
  end

  assign o_discardCount = r_discardCount;
`else
  logic w_unusedDiscard;
  assign w_unusedDiscard = w_discard;
`endif

  assign o_bit        = r_bit;
  assign o_bitValid   = r_bitValid;
  assign o_ready      = r_ready;
  assign o_healthFail = r_healthFail;
  assign o_failCause  = r_failCause;

endmodule
